// File: rtl/scfifo_param.sv
// rtl/scfifo_param.sv - parametrised single-clock FIFO with thresholds and show-ahead read
module scfifo_param #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4,
    parameter int AF_LVL = 12,
    parameter int AE_LVL = 4,
    parameter int FWFT   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd_n,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LVL);
    localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LVL);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W:0]   r_wr_ptr;
    logic [ADDR_W:0]   r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic [DATA_W-1:0] r_data_out;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_full;
    logic              w_empty;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [ADDR_W:0]   w_wr_ptr_nxt;
    logic [ADDR_W:0]   w_rd_ptr_nxt;
    logic [DATA_W-1:0] w_head;

    // Flags decode straight from the registered occupancy
    assign w_full       = (r_count == DEPTH_C);
    assign w_empty      = (r_count == '0);
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= AF_C);
    assign almost_empty = (r_count < AE_C);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // A request is only accepted when the FIFO state allows it; rejected ones touch nothing
    assign w_wr_acc     = ~wr_n & ~w_full;
    assign w_rd_acc     = ~rd_n & ~w_empty;
    assign w_wr_ptr_nxt = r_wr_ptr + {{ADDR_W{1'b0}}, w_wr_acc};
    assign w_rd_ptr_nxt = r_rd_ptr + {{ADDR_W{1'b0}}, w_rd_acc};

    assign w_head   = r_mem[r_rd_ptr[ADDR_W-1:0]];
    assign data_out = (FWFT != 0) ? w_head : r_data_out;

    // Storage array; deliberately not reset, stale words are unreachable after pointer reset
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= data_in;
        end
    end

    // Pointers and occupancy; the extra pointer bit disambiguates full from empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_wr_ptr_nxt - w_rd_ptr_nxt;
        end
    end

    // Registered read port for standard mode, holds between accepted reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_out <= '0;
        end else if (w_rd_acc) begin
            r_data_out <= w_head;
        end
    end

    // Error pulses are high only for the cycle following the offending request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= ~wr_n & w_full;
            r_underflow <= ~rd_n & w_empty;
        end
    end

endmodule

// File: tb/tb_scfifo_param.sv
// tb/tb_scfifo_param.sv - randomized self-checking bench for scfifo_param against a queue model
module tb_scfifo_param;

    localparam int DW    = 4;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int AE    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_n = 1'b1;
    logic          rd_n = 1'b1;
    logic [DW-1:0] data_in = '0;

    logic [DW-1:0] s_dout, f_dout;
    logic          s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic          f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [AW:0]   s_count, f_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] model_q[$];
    logic [DW-1:0] exp_dout = '0;
    logic          exp_ovf  = 1'b0;
    logic          exp_unf  = 1'b0;

    always #5 clk = ~clk;

    scfifo_param #(.DATA_W(DW), .ADDR_W(AW), .AF_LVL(AF), .AE_LVL(AE), .FWFT(0)) u_std (
        .clk(clk), .rst_n(rst_n), .wr_n(wr_n), .data_in(data_in), .rd_n(rd_n),
        .data_out(s_dout), .full(s_full), .empty(s_empty), .almost_full(s_af),
        .almost_empty(s_ae), .count(s_count), .overflow(s_ovf), .underflow(s_unf)
    );

    scfifo_param #(.DATA_W(DW), .ADDR_W(AW), .AF_LVL(AF), .AE_LVL(AE), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .wr_n(wr_n), .data_in(data_in), .rd_n(rd_n),
        .data_out(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_af),
        .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_unf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    // Compare every visible output of both instances against the model
    task automatic check_all(input string tag);
        int sz;
        sz = model_q.size();
        check({tag, " count"},    32'(s_count), 32'(sz));
        check({tag, " full"},     32'(s_full),  32'(sz == DEPTH));
        check({tag, " empty"},    32'(s_empty), 32'(sz == 0));
        check({tag, " afull"},    32'(s_af),    32'(sz >= AF));
        check({tag, " aempty"},   32'(s_ae),    32'(sz < AE));
        check({tag, " ovf"},      32'(s_ovf),   32'(exp_ovf));
        check({tag, " unf"},      32'(s_unf),   32'(exp_unf));
        check({tag, " dout"},     32'(s_dout),  32'(exp_dout));
        check({tag, " f_count"},  32'(f_count), 32'(sz));
        check({tag, " f_flags"},  32'({f_full, f_empty, f_af, f_ae, f_ovf, f_unf}),
              32'({sz == DEPTH, sz == 0, sz >= AF, sz < AE, exp_ovf, exp_unf}));
        if (sz > 0) begin
            check({tag, " f_dout"}, 32'(f_dout), 32'(model_q[0]));
        end
    endtask

    // One clock: drive at the falling edge, update the model at the rising edge, sample 1ns later
    task automatic step(input string tag, input bit wr, input logic [DW-1:0] d, input bit rd);
        bit is_full, is_empty;
        @(negedge clk);
        wr_n    = ~wr;
        rd_n    = ~rd;
        data_in = d;
        is_full  = (model_q.size() == DEPTH);
        is_empty = (model_q.size() == 0);
        @(posedge clk);
        exp_ovf = wr && is_full;
        exp_unf = rd && is_empty;
        if (rd && !is_empty) exp_dout = model_q.pop_front();
        if (wr && !is_full) model_q.push_back(d);
        #1;
        check_all(tag);
    endtask

    task automatic model_reset();
        model_q.delete();
        exp_dout = '0;
        exp_ovf  = 1'b0;
        exp_unf  = 1'b0;
    endtask

    logic [DW-1:0] inc;

    initial begin
        // Reset values
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Fill with 1..F,0 walking through every threshold
        for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, DW'(i + 1), 1'b0);
        // Write into a full FIFO
        step("ovf", 1'b1, 4'hF, 1'b0);
        step("ovf_clear", 1'b0, 4'h0, 1'b0);
        // Full with both requested: read wins, write dropped
        step("full_both", 1'b1, 4'h7, 1'b1);
        step("refill", 1'b1, 4'h9, 1'b0);
        // Drain in order
        for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, 4'h0, 1'b1);
        // Underflow twice, data_out holds
        step("unf", 1'b0, 4'h0, 1'b1);
        step("unf", 1'b0, 4'h0, 1'b1);
        // Empty with both requested: only the write lands
        step("empty_both", 1'b1, 4'hA, 1'b1);
        step("fwft_read", 1'b0, 4'h0, 1'b1);

        // Sustained simultaneous traffic at count 5 across pointer wraps
        inc = 4'h0;
        for (int i = 0; i < 5; i++) begin
            step("pre5", 1'b1, inc, 1'b0);
            inc++;
        end
        for (int i = 0; i < 40; i++) begin
            step("both40", 1'b1, inc, 1'b1);
            inc++;
        end

        // Grow to 9 then reset mid-cycle
        for (int i = 0; i < 4; i++) step("to9", 1'b1, DW'(i + 3), 1'b0);
        check("count9", 32'(s_count), 32'd9);
        @(negedge clk);
        wr_n = 1'b1;
        rd_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async count", 32'(s_count), 32'd0);
        check("async empty", 32'(s_empty), 32'd1);
        check("async dout", 32'(s_dout), 32'd0);
        check("async f_count", 32'(f_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst_wr", 1'b1, 4'h5, 1'b0);
        step("post_rst_rd", 1'b0, 4'h0, 1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(0, 99) < 55), DW'($urandom), ($urandom_range(0, 99) < 45));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

endmodule

// File: doc/scfifo_param.md
# scfifo_param

Parametrised single-clock FIFO, the successor to the fixed 4-bit × 16 slave FIFO in the MCDF slave path. It adds configurable data width, depth, almost-full/almost-empty thresholds and a show-ahead (first-word-fall-through) mode. It also provides true full/empty, an occupancy count, and overflow/underflow error pulses. Storage is an internal register array, so no external memory instance is needed. It sits between a slave channel's write side and the arbiter's read side.

## Interface
- DATA_W, 4, data word width in bits (≥1)
- ADDR_W, 4, address width; DEPTH = 2^ADDR_W words
- AF_LVL, 12, almost_full asserts when count ≥ AF_LVL (1..DEPTH)
- AE_LVL, 4, almost_empty asserts when count < AE_LVL (0..DEPTH)
- FWFT, 0, 0 = standard registered read; 1 = show-ahead read

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- wr_n  in  1  write request, active-low
- data_in  in  DATA_W  write data
- rd_n  in  1  read request, active-low
- data_out  out  DATA_W  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_LVL
- almost_empty  out  1  count < AE_LVL
- count  out  ADDR_W+1  current occupancy, 0..DEPTH
- overflow  out  1  one-cycle pulse: write requested while full
- underflow  out  1  one-cycle pulse: read requested while empty

## Operation
- Pointers: wr_ptr and rd_ptr are ADDR_W+1 bits each.
  - Low ADDR_W bits address the array.
  - Both wrap modulo 2^(ADDR_W+1).
  - count = wr_ptr − rd_ptr, computed modulo 2^(ADDR_W+1) and held registered.
- Write accept: wr_n==0 && !full.
  - mem[wr_ptr[ADDR_W-1:0]] ← data_in.
  - wr_ptr increments.
- Read accept: rd_n==0 && !empty.
  - rd_ptr increments.
- Both accepted in the same cycle: count is unchanged.
- Full with both requested:
  - Only the read is accepted; the write is dropped.
  - overflow pulses; count becomes DEPTH−1.
- Empty with both requested:
  - Only the write is accepted; there is no read-through.
  - underflow pulses; count becomes 1.
- Rejected requests leave pointers, memory and data_out untouched.
- Flag decode:
  - full, empty, almost_full and almost_empty decode combinationally from the registered count.
  - They are glitch-free with respect to registers only.
- Standard mode (FWFT=0):
  - On an accepted read, data_out ← mem[rd_ptr] at that edge.
  - Otherwise data_out holds its last value.
- Show-ahead mode (FWFT=1):
  - data_out = mem[rd_ptr[ADDR_W-1:0]] combinationally; it is the head word whenever !empty.
  - When empty, data_out is undefined.
  - An accepted read advances to the next word.
- overflow and underflow:
  - Registered, high for exactly the cycle after the offending edge.
  - Not sticky.

## Timing
- Reset (rst_n low, async) sets:
  - wr_ptr = rd_ptr = count = 0, data_out = 0.
  - empty = 1, full = 0, almost_full = 0.
  - almost_empty = (AE_LVL > 0).
  - overflow = underflow = 0.
- Memory contents are not reset.
- Reset asserted mid-operation discards all stored words immediately; nothing is flushed.
- Deassertion is sampled on the next rising edge.
- Write-to-flag latency: count and flags update at the edge that accepts the request, visible in the following cycle.
- Write-to-read latency:
  - A word written at edge N is readable at edge N+1.
  - Standard mode: data_out is valid after edge N+1 if rd_n was low.
  - FWFT: data_out is valid after edge N, so first data is visible in the cycle after the write.
- Back-to-back reads and writes are sustained at one per cycle each.
- Wrap-around: pointer rollover is invisible externally. After DEPTH·k writes and reads, count and flags are exact.

## Test plan
- Reset, then 16 writes of 0x1..0x0 (wr_n low, rd_n high):
  - count steps 1..16.
  - almost_empty drops when count reaches 4.
  - almost_full rises at count 12.
  - full rises at 16; empty stays 0 from the first write.
- Full FIFO plus a 17th write of 0xF:
  - overflow pulses one cycle; count stays 16.
  - Subsequently 16 reads return 0x1..0x0 in order, then empty = 1.
- Empty FIFO plus rd_n low for 2 cycles:
  - underflow pulses for 2 cycles; count stays 0.
  - data_out holds 0 (FWFT=0).
- Simultaneous wr_n and rd_n low for 40 cycles at count 5, with incrementing data:
  - count stays 5 throughout; pointers wrap twice.
  - Read data sequence is strictly in write order.
- FWFT=1, write 0xA at edge N:
  - data_out = 0xA in cycle N+1 with no read.
  - A read at N+1 gives empty = 1 at N+2.
- rst_n pulsed low asynchronously mid-cycle at count 9:
  - All outputs go to reset values before the next edge.
  - A following write/read returns the new data, not stale words.
